ofifo_align: RTL and testbench
==============================

# ofifo_align

Column-aligned output FIFO between the last PE row of the systolic array and the SFU's `psum_in`. Each array column delivers partial sums on its own cycle because of systolic skew. This block buffers each column independently. It releases one complete, time-aligned row of `col` psums only when every column holds data, so the SFU always sees a coherent vector.

## Interface
- `col`, 8, number of array columns / FIFO lanes
- `psum_bw`, 16, bits per psum
- `depth`, 8, entries per lane; power of two, ≥2

- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low; reset is taken on a rising `clk` edge while `reset`=0
- `wr_i`  in  `col`  per-lane write strobe; bit k writes lane k
- `in`  in  `col*psum_bw`  lane k data at bits [(k+1)*psum_bw-1 : k*psum_bw]
- `rd_i`  in  1  pop one full row
- `out`  out  `col*psum_bw`  registered row output, same lane packing as `in`
- `o_valid`  out  1  one-cycle pulse: `out` holds a newly popped row
- `o_ready`  out  1  every lane non-empty (a row is available)
- `o_full`  out  1  any lane full
- `o_ovf`  out  1  sticky: a write was dropped
- `o_udf`  out  1  sticky: a read was ignored

## Operation
- Storage: `col` circular buffers of `depth` × `psum_bw`.
- Pointers:
  - one write pointer per lane
  - one shared read pointer, because rows always pop together
  - all pointers are log2(depth)+1 bits, with the MSB used as the wrap bit
- Per-lane occupancy: cnt[k] = wptr[k] − rptr (modular). Empty when cnt=0; full when cnt=depth.
- Flags are combinational from the current registered state:
  - `o_ready` = AND over k of (cnt[k] ≠ 0)
  - `o_full` = OR over k of (cnt[k] = depth)
- Write, lane k: if wr_i[k] and lane k is not full, store in[k] at wptr[k], then increment wptr[k].
  - If wr_i[k] and lane k is full, drop the data and set `o_ovf`. The lane is unchanged.
- Read: if rd_i and `o_ready`, capture every lane's entry at rptr into `out`, increment rptr, and assert `o_valid` on the next cycle.
  - If rd_i and not `o_ready`, set `o_udf`. `out` holds its value, `o_valid`=0, and pointers are unchanged.
- Simultaneous read and write on the same lane:
  - Both are evaluated against pre-edge state.
  - A write to a lane that is full at the pre-edge state is dropped even if a read pops that same cycle. There is no same-cycle slot reuse.
  - A write to an empty lane does not satisfy a same-cycle read. No bypass.
- Wrap-around: pointers roll over modulo 2·depth. Data order within each lane is strict FIFO across wrap.
- `out` holds the last popped row until the next accepted read.
- `o_ovf` and `o_udf` clear only on reset.

## Timing
- Reset (`reset`=0 at an edge) sets all of the following to 0:
  - every wptr and rptr
  - `out`, `o_valid`, `o_ovf`, `o_udf`
  - therefore `o_ready`=0 and `o_full`=0
- Buffer contents are not reset.
- Reset applied mid-operation discards all queued rows. The first edge with `reset`=1 may accept writes.
- Reset takes priority over wr_i and rd_i in the same cycle.
- Write-to-ready latency: `o_ready` rises the cycle after the edge that writes the last empty lane.
- Read latency: rd_i sampled at edge N gives `out`/`o_valid` valid after edge N. `o_valid` stays high for exactly one cycle per accepted read.
- Back-to-back reads are allowed every cycle while `o_ready`=1.
- `o_ready` falls the cycle after the pop that empties any lane.
- `o_full` reflects post-edge state and may be sampled by the array controller to stall.

## Test plan
- Skewed fill:
  - Stimulus: write lane k at cycle k (k=0..7) with 0x0100+k.
  - Required: `o_ready`=0 through the cycle lane 7 is written, and 1 the next cycle.
  - Stimulus: pulse rd_i.
  - Required: next cycle `out`=0x0107_0106_…_0100, `o_valid`=1 for one cycle, then `o_ready`=0.
- Overflow:
  - Stimulus: 9 writes to lane 0 (values 1..9) with no reads.
  - Required: `o_full`=1 after the 8th; the 9th is dropped and `o_ovf`=1.
  - Stimulus: fill other lanes, then pop 8 rows.
  - Required: lane 0 yields 1..8 in order.
- Underflow:
  - Stimulus: rd_i with lanes 0–6 holding 1 entry and lane 7 empty.
  - Required: `o_udf`=1, `o_valid`=0, `out` unchanged, lanes 0–6 still cnt=1.
- Streaming wrap:
  - Stimulus: write all lanes every cycle for 20 rows, with row r, lane k = r·16+k. Read every cycle once `o_ready`=1.
  - Required: 20 `o_valid` pulses, rows in order with exact values, `o_ovf`=`o_udf`=0.
- Full-lane simultaneous event:
  - Stimulus: with lane 3 full and all lanes non-empty, assert rd_i and wr_i[3] in the same cycle.
  - Required: the row pops, the lane 3 write is dropped, `o_ovf`=1, and lane 3 cnt=7.
- Reset mid-stream:
  - Stimulus: with 4 rows queued and `o_ovf`=1, hold `reset`=0 for one edge.
  - Required: `o_ready`, `o_full`, `o_valid`, `o_ovf`, `o_udf` are 0 and `out`=0.
  - Stimulus: a fresh single-row write then rd_i.
  - Required: returns only the new data.

Source files
------------

// File: rtl/ofifo_align.sv
`default_nettype none
// ============================================================================
// Module   : ofifo_align
// Purpose  : Per-column psum FIFOs that release one time-aligned row at a time.
// Revision : 1.0
// ============================================================================
module ofifo_align #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [col-1:0]           wr_i,
    input  logic [col*psum_bw-1:0]   in,
    input  logic                     rd_i,
    output logic [col*psum_bw-1:0]   out,
    output logic                     o_valid,
    output logic                     o_ready,
    output logic                     o_full,
    output logic                     o_ovf,
    output logic                     o_udf
);

    localparam int AW = $clog2(depth);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_CNT = PW'(depth);

    logic [PW-1:0]           rptr;
    logic [col-1:0]          lane_full;
    logic [col-1:0]          lane_nonempty;
    logic [col*psum_bw-1:0]  head_row;
    logic                    pop;

    // One shared read pointer; each lane owns its write pointer and storage.
    for (genvar k = 0; k < col; k++) begin : g_lane
        logic [psum_bw-1:0] mem [depth];
        logic [PW-1:0]      wptr;
        logic [PW-1:0]      cnt;
        logic               push;

        assign cnt              = wptr - rptr;
        assign lane_full[k]     = (cnt == DEPTH_CNT);
        assign lane_nonempty[k] = (cnt != '0);
        assign push             = wr_i[k] && !lane_full[k];
        assign head_row[k*psum_bw +: psum_bw] = mem[rptr[AW-1:0]];

        always_ff @(posedge clk) begin
            if (!reset) begin
                wptr <= '0;
            end else if (push) begin
                wptr <= wptr + 1'b1;
            end
        end

        // Storage is intentionally not cleared; pointers alone define contents.
        always_ff @(posedge clk) begin
            if (reset && push) begin
                mem[wptr[AW-1:0]] <= in[k*psum_bw +: psum_bw];
            end
        end
    end

    always_comb begin
        o_ready = &lane_nonempty;
        o_full  = |lane_full;
        pop     = rd_i && o_ready;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rptr    <= '0;
            out     <= '0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
            o_udf   <= 1'b0;
        end else begin
            o_valid <= pop;
            if (pop) begin
                out  <= head_row;
                rptr <= rptr + 1'b1;
            end
            if (rd_i && !o_ready) begin
                o_udf <= 1'b1;
            end
            if (|(wr_i & lane_full)) begin
                o_ovf <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ofifo_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_ofifo_align
// Purpose  : Directed self-checking bench for ofifo_align.
// Revision : 1.0
// ============================================================================
module tb_ofifo_align;

    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int W   = COL * BW;

    logic           clk;
    logic           reset;
    logic [COL-1:0] wr_i;
    logic [W-1:0]   in;
    logic           rd_i;
    logic [W-1:0]   out;
    logic           o_valid, o_ready, o_full, o_ovf, o_udf;

    int n_checks = 0;
    int n_pass   = 0;

    ofifo_align #(.col(COL), .psum_bw(BW), .depth(8)) dut (
        .clk(clk), .reset(reset), .wr_i(wr_i), .in(in), .rd_i(rd_i),
        .out(out), .o_valid(o_valid), .o_ready(o_ready), .o_full(o_full),
        .o_ovf(o_ovf), .o_udf(o_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Lane k of the returned row is base + k.
    function automatic logic [W-1:0] mkrow(input int base);
        logic [W-1:0] r;
        for (int k = 0; k < COL; k++) r[k*BW +: BW] = BW'(base + k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] exp_row;
    logic [W-1:0] held;
    int           rrow;
    int           wrow;

    initial begin
        reset = 1'b0; wr_i = '0; in = '0; rd_i = 1'b0;
        tick(); tick();
        reset = 1'b1;
        check("rst_ready", W'(o_ready), W'(0));
        check("rst_full",  W'(o_full),  W'(0));
        check("rst_valid", W'(o_valid), W'(0));
        check("rst_flags", W'({o_ovf, o_udf}), W'(0));
        check("rst_out",   out, '0);

        // Skewed fill, one lane per cycle.
        in = mkrow(16'h0100);
        for (int k = 0; k < COL; k++) begin
            wr_i = COL'(1) << k;
            tick();
            check($sformatf("skew_ready_%0d", k), W'(o_ready), W'(k == COL-1));
        end
        wr_i = '0;
        rd_i = 1'b1; tick(); rd_i = 1'b0;
        check("skew_out",   out, mkrow(16'h0100));
        check("skew_valid", W'(o_valid), W'(1));
        check("skew_ready_after", W'(o_ready), W'(0));
        tick();
        check("skew_valid_pulse", W'(o_valid), W'(0));

        // Underflow: lanes 0-6 hold one entry, lane 7 empty.
        wr_i = 8'h7F; in = mkrow(16'h0020); tick();
        wr_i = '0;
        rd_i = 1'b1; tick(); rd_i = 1'b0;
        check("udf_flag",  W'(o_udf),   W'(1));
        check("udf_valid", W'(o_valid), W'(0));
        check("udf_out",   out, mkrow(16'h0100));
        wr_i = 8'h80; tick(); wr_i = '0;
        check("udf_ready_after_fill", W'(o_ready), W'(1));
        rd_i = 1'b1; tick(); rd_i = 1'b0;
        check("udf_pop_out", out, mkrow(16'h0020));
        check("udf_lanes_single", W'(o_ready), W'(0));

        // Overflow on lane 0.
        for (int i = 1; i <= 9; i++) begin
            wr_i = 8'h01; in = '0; in[BW-1:0] = BW'(i);
            tick();
            check($sformatf("ovf_full_%0d", i), W'(o_full), W'(i >= 8));
            check($sformatf("ovf_flag_%0d", i), W'(o_ovf),  W'(i == 9));
        end
        for (int i = 0; i < 8; i++) begin
            wr_i = 8'hFE; in = mkrow(16'h1000 + i*16);
            tick();
        end
        wr_i = '0;
        for (int i = 0; i < 8; i++) begin
            rd_i = 1'b1; tick(); rd_i = 1'b0;
            exp_row = mkrow(16'h1000 + i*16);
            exp_row[BW-1:0] = BW'(i + 1);
            check($sformatf("ovf_pop_%0d", i), out, exp_row);
        end
        check("ovf_drained", W'({o_ready, o_full}), W'(0));

        // Reset mid-stream, colliding with a read request.
        for (int i = 0; i < 4; i++) begin
            wr_i = 8'hFF; in = mkrow(16'h0500 + i*16); tick();
        end
        wr_i = '0;
        reset = 1'b0; rd_i = 1'b1; tick(); reset = 1'b1; rd_i = 1'b0;
        check("mrst_ready", W'(o_ready), W'(0));
        check("mrst_full",  W'(o_full),  W'(0));
        check("mrst_valid", W'(o_valid), W'(0));
        check("mrst_ovf",   W'(o_ovf),   W'(0));
        check("mrst_udf",   W'(o_udf),   W'(0));
        check("mrst_out",   out, '0);
        wr_i = 8'hFF; in = mkrow(16'h0600); tick(); wr_i = '0;
        rd_i = 1'b1; tick(); rd_i = 1'b0;
        check("mrst_fresh_out", out, mkrow(16'h0600));
        check("mrst_fresh_only", W'(o_ready), W'(0));

        // Lane 3 full, pop and write it in the same cycle.
        wr_i = 8'hFF; in = mkrow(16'h0700); tick();
        for (int j = 1; j <= 7; j++) begin
            wr_i = 8'h08; in = '0; in[3*BW +: BW] = BW'(16'h0730 + j); tick();
        end
        check("sim_full_before", W'(o_full), W'(1));
        wr_i = 8'h08; in = '0; in[3*BW +: BW] = 16'h0BAD; rd_i = 1'b1;
        tick();
        wr_i = '0; rd_i = 1'b0;
        check("sim_pop_out", out, mkrow(16'h0700));
        check("sim_valid",   W'(o_valid), W'(1));
        check("sim_ovf",     W'(o_ovf),   W'(1));
        check("sim_full_after", W'(o_full), W'(0));
        for (int j = 0; j < 7; j++) begin
            wr_i = 8'hF7; in = mkrow(16'h0800); tick();
        end
        wr_i = '0;
        for (int j = 1; j <= 7; j++) begin
            rd_i = 1'b1; tick(); rd_i = 1'b0;
            held = out;
            check($sformatf("sim_lane3_%0d", j), W'(held[3*BW +: BW]), W'(16'h0730 + j));
        end
        check("sim_lane3_cnt7", W'(o_ready), W'(0));

        // Streaming with wrap.
        reset = 1'b0; tick(); reset = 1'b1;
        rrow = 0; wrow = 0;
        for (int c = 0; c < 60 && rrow < 20; c++) begin
            wr_i = (wrow < 20) ? 8'hFF : 8'h00;
            in   = mkrow(wrow * 16);
            rd_i = o_ready;
            tick();
            if (wrow < 20) wrow++;
            if (o_valid) begin
                check($sformatf("stream_row_%0d", rrow), out, mkrow(rrow * 16));
                rrow++;
            end
        end
        wr_i = '0; rd_i = 1'b0;
        check("stream_count", W'(rrow), W'(20));
        check("stream_flags", W'({o_ovf, o_udf}), W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
